// File: rtl/dual_port_ram_ext.sv
// ============================================================================
// Module   : dual_port_ram_ext
// Summary  : Simple dual-port RAM with byte enables, read-during-write policy,
//            optional output register and post-reset zero-fill sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_port_ram_ext #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int RDW_NEW_DATA   = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    write_en,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    input  logic                    read_en,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    init_busy
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("dual_port_ram_ext: DATA_WIDTH must be a positive multiple of 8");
    end

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t ST_AFTER_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_AFTER_RESET;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                cnt_d  = cnt_q + 1'b1;
                busy_d = 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign init_busy = busy_q;

    // User accesses only count once the sequencer has released the array.
    logic w_clr, w_acc, w_rd;
    assign w_clr = reset_n && (state_q == ST_CLEAR);
    assign w_acc = reset_n && (state_q == ST_READY);
    assign w_rd  = w_acc && read_en;

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_data;
    logic [NBYTES-1:0]     w_mem_be;

    assign w_mem_we   = w_clr || (w_acc && write_en);
    assign w_mem_addr = w_clr ? cnt_q : waddr;
    assign w_mem_data = w_clr ? '0 : din;
    assign w_mem_be   = w_clr ? {NBYTES{1'b1}} : byte_en;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (w_mem_we && w_mem_be[i]) begin
                mem_q[w_mem_addr][8*i +: 8] <= w_mem_data[8*i +: 8];
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_word_q;
    logic                  rd_vld_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_word_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_vld_q <= w_rd;
            if (w_rd) begin
                rd_word_q <= mem_q[raddr];
            end
        end
    end

    // Same-address forwarding captured beside the array; merged after it.
    logic [NBYTES-1:0]     fwd_be_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    if (RDW_NEW_DATA != 0) begin : g_fwd
        logic [NBYTES-1:0] w_fwd_be;
        assign w_fwd_be = (write_en && (raddr == waddr)) ? byte_en : '0;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                fwd_be_q   <= '0;
                fwd_data_q <= '0;
            end else if (w_rd) begin
                fwd_be_q   <= w_fwd_be;
                fwd_data_q <= din;
            end
        end
    end else begin : g_nofwd
        assign fwd_be_q   = '0;
        assign fwd_data_q = '0;
    end

    logic [DATA_WIDTH-1:0] w_merged;

    always_comb begin
        w_merged = rd_word_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (fwd_be_q[i]) begin
                w_merged[8*i +: 8] = fwd_data_q[8*i +: 8];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_q;
        logic                  out_vld_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                out_q     <= '0;
                out_vld_q <= 1'b0;
            end else begin
                out_vld_q <= rd_vld_q;
                if (rd_vld_q) begin
                    out_q <= w_merged;
                end
            end
        end

        assign dout       = out_q;
        assign dout_valid = out_vld_q;
    end else begin : g_out_direct
        assign dout       = w_merged;
        assign dout_valid = rd_vld_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_dual_port_ram_ext.sv
// ============================================================================
// Module   : tb_dual_port_ram_ext
// Summary  : Directed bench driving three RAM configurations in lock-step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual_port_ram_ext;

    logic        clk;
    logic        reset_n;
    logic [4:0]  waddr;
    logic [31:0] din;
    logic        write_en;
    logic [3:0]  byte_en;
    logic [4:0]  raddr;
    logic        read_en;

    logic [31:0] dout0, dout1, dout2;
    logic        dv0, dv1, dv2;
    logic        busy0, busy1, busy2;

    int checks = 0;
    int errors = 0;

    // dut0: old-data RDW, latency 1, clear on reset
    dual_port_ram_ext #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .RDW_NEW_DATA(0),
                        .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .waddr(waddr), .din(din),
        .write_en(write_en), .byte_en(byte_en), .raddr(raddr),
        .read_en(read_en), .dout(dout0), .dout_valid(dv0), .init_busy(busy0));

    // dut1: new-data RDW, latency 2, clear on reset
    dual_port_ram_ext #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .RDW_NEW_DATA(1),
                        .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .waddr(waddr), .din(din),
        .write_en(write_en), .byte_en(byte_en), .raddr(raddr),
        .read_en(read_en), .dout(dout1), .dout_valid(dv1), .init_busy(busy1));

    // dut2: no clear sequence
    dual_port_ram_ext #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .RDW_NEW_DATA(0),
                        .OUT_REG(0), .CLEAR_ON_RESET(0)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .waddr(waddr), .din(din),
        .write_en(write_en), .byte_en(byte_en), .raddr(raddr),
        .read_en(read_en), .dout(dout2), .dout_valid(dv2), .init_busy(busy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        waddr    = a;
        din      = d;
        byte_en  = be;
        write_en = 1'b1;
        step();
        write_en = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        step();
        step();
        checks++; if (dout0 !== 32'h0) begin errors++; $display("FAIL reset_dout0: got %h want %h", dout0, 32'h0); end
        checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b want 0", dv0); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL reset_busy0: got %b want 1", busy0); end
        checks++; if (dout1 !== 32'h0) begin errors++; $display("FAIL reset_dout1: got %h want %h", dout1, 32'h0); end
        checks++; if (dv1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b want 0", dv1); end
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL reset_busy2: got %b want 1", busy2); end
    endtask

    task automatic test_clear;
        int n = 0;
        reset_n = 1'b1;
        do begin
            step();
            n++;
            if (n == 1) begin
                checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL noclear_busy_first: got %b want 0", busy2); end
            end
        end while (busy0 === 1'b1 && n < 100);
        checks++; if (n != 32) begin errors++; $display("FAIL clear_cycles: got %0d want 32", n); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL clear_busy1_end: got %b want 0", busy1); end
    endtask

    task automatic test_byte_en;
        wr(5'd3, 32'h11223344, 4'hF);
        wr(5'd3, 32'hAABBCCDD, 4'b0101);
        raddr = 5'd3; read_en = 1'b1;
        step();
        read_en = 1'b0;
        checks++; if (dout0 !== 32'h11BB33DD) begin errors++; $display("FAIL byte_en_dout0: got %h want %h", dout0, 32'h11BB33DD); end
        checks++; if (dv0 !== 1'b1) begin errors++; $display("FAIL byte_en_valid0: got %b want 1", dv0); end
        checks++; if (dv1 !== 1'b0) begin errors++; $display("FAIL byte_en_valid1_early: got %b want 0", dv1); end
        step();
        checks++; if (dout1 !== 32'h11BB33DD) begin errors++; $display("FAIL byte_en_dout1: got %h want %h", dout1, 32'h11BB33DD); end
        checks++; if (dv1 !== 1'b1) begin errors++; $display("FAIL byte_en_valid1: got %b want 1", dv1); end
        checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL byte_en_valid0_pulse: got %b want 0", dv0); end
        checks++; if (dout0 !== 32'h11BB33DD) begin errors++; $display("FAIL byte_en_dout0_hold: got %h want %h", dout0, 32'h11BB33DD); end
        step();
    endtask

    task automatic test_rdw;
        wr(5'd5, 32'h0, 4'hF);
        waddr = 5'd5; din = 32'hCAFEF00D; byte_en = 4'b0011; write_en = 1'b1;
        raddr = 5'd5; read_en = 1'b1;
        step();
        write_en = 1'b0; read_en = 1'b0;
        checks++; if (dout0 !== 32'h0) begin errors++; $display("FAIL rdw_old_dout0: got %h want %h", dout0, 32'h0); end
        step();
        checks++; if (dout1 !== 32'h0000F00D) begin errors++; $display("FAIL rdw_new_dout1: got %h want %h", dout1, 32'h0000F00D); end
        checks++; if (dv1 !== 1'b1) begin errors++; $display("FAIL rdw_new_valid1: got %b want 1", dv1); end
        waddr = 5'd6; din = 32'hFFFFFFFF; byte_en = 4'hF; write_en = 1'b1;
        raddr = 5'd5; read_en = 1'b1;
        step();
        write_en = 1'b0; read_en = 1'b0;
        checks++; if (dout0 !== 32'h0000F00D) begin errors++; $display("FAIL rdw_diff_dout0: got %h want %h", dout0, 32'h0000F00D); end
        step();
        checks++; if (dout1 !== 32'h0000F00D) begin errors++; $display("FAIL rdw_diff_dout1: got %h want %h", dout1, 32'h0000F00D); end
        step();
    endtask

    task automatic test_back_to_back;
        wr(5'd0, 32'd10, 4'hF);
        wr(5'd1, 32'd20, 4'hF);
        wr(5'd2, 32'd30, 4'hF);
        raddr = 5'd0; read_en = 1'b1;
        step();
        checks++; if (dout0 !== 32'd10 || dv0 !== 1'b1) begin errors++; $display("FAIL b2b_dout0_a: got %0d/%b want 10/1", dout0, dv0); end
        checks++; if (dv1 !== 1'b0) begin errors++; $display("FAIL b2b_valid1_lat: got %b want 0", dv1); end
        raddr = 5'd1;
        step();
        checks++; if (dout0 !== 32'd20) begin errors++; $display("FAIL b2b_dout0_b: got %0d want 20", dout0); end
        checks++; if (dout1 !== 32'd10 || dv1 !== 1'b1) begin errors++; $display("FAIL b2b_dout1_a: got %0d/%b want 10/1", dout1, dv1); end
        raddr = 5'd2;
        step();
        read_en = 1'b0;
        checks++; if (dout0 !== 32'd30) begin errors++; $display("FAIL b2b_dout0_c: got %0d want 30", dout0); end
        checks++; if (dout1 !== 32'd20 || dv1 !== 1'b1) begin errors++; $display("FAIL b2b_dout1_b: got %0d/%b want 20/1", dout1, dv1); end
        step();
        checks++; if (dout0 !== 32'd30 || dv0 !== 1'b0) begin errors++; $display("FAIL b2b_dout0_hold: got %0d/%b want 30/0", dout0, dv0); end
        checks++; if (dout1 !== 32'd30 || dv1 !== 1'b1) begin errors++; $display("FAIL b2b_dout1_c: got %0d/%b want 30/1", dout1, dv1); end
        step();
        checks++; if (dout1 !== 32'd30 || dv1 !== 1'b0) begin errors++; $display("FAIL b2b_dout1_hold: got %0d/%b want 30/0", dout1, dv1); end
    endtask

    task automatic test_clear_preload;
        int n = 0;
        wr(5'd7, 32'hDEADBEEF, 4'hF);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        while (busy0 === 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++; if (n != 32) begin errors++; $display("FAIL preload_clear_cycles: got %0d want 32", n); end
        checks++; if (dout0 !== 32'h0 || dv0 !== 1'b0) begin errors++; $display("FAIL preload_dout0_reset: got %h/%b want 0/0", dout0, dv0); end
        raddr = 5'd7; read_en = 1'b1;
        step();
        read_en = 1'b0;
        checks++; if (dout0 !== 32'h0 || dv0 !== 1'b1) begin errors++; $display("FAIL preload_read0: got %h/%b want 0/1", dout0, dv0); end
        checks++; if (dout2 !== 32'hDEADBEEF) begin errors++; $display("FAIL preload_read2: got %h want %h", dout2, 32'hDEADBEEF); end
        step();
        checks++; if (dout1 !== 32'h0 || dv1 !== 1'b1) begin errors++; $display("FAIL preload_read1: got %h/%b want 0/1", dout1, dv1); end
    endtask

    task automatic test_reset_mid_clear;
        int n = 0;
        logic seen_valid = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        waddr = 5'd2; din = 32'h55555555; byte_en = 4'hF; write_en = 1'b1;
        raddr = 5'd2; read_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (dv0 === 1'b1 || dv1 === 1'b1) seen_valid = 1'b1;
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        while (busy0 === 1'b1 && n < 100) begin
            step();
            n++;
            if (dv0 === 1'b1 || dv1 === 1'b1) seen_valid = 1'b1;
        end
        write_en = 1'b0; read_en = 1'b0;
        checks++; if (n != 32) begin errors++; $display("FAIL midclear_cycles: got %0d want 32", n); end
        checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL midclear_valid: got %b want 0", seen_valid); end
        step();
        checks++; if (dv0 !== 1'b0 || dv1 !== 1'b0) begin errors++; $display("FAIL midclear_valid_after: got %b%b want 00", dv0, dv1); end
        raddr = 5'd2; read_en = 1'b1;
        step();
        read_en = 1'b0;
        checks++; if (dout0 !== 32'h0) begin errors++; $display("FAIL midclear_read0: got %h want %h", dout0, 32'h0); end
        step();
        checks++; if (dout1 !== 32'h0) begin errors++; $display("FAIL midclear_read1: got %h want %h", dout1, 32'h0); end
    endtask

    task automatic test_no_clear;
        int n = 0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        waddr = 5'd20; din = 32'h12345678; byte_en = 4'hF; write_en = 1'b1;
        step();
        write_en = 1'b0;
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL noclear_busy: got %b want 0", busy2); end
        raddr = 5'd20; read_en = 1'b1;
        step();
        read_en = 1'b0;
        checks++; if (dout2 !== 32'h12345678 || dv2 !== 1'b1) begin errors++; $display("FAIL noclear_read: got %h/%b want %h/1", dout2, dv2, 32'h12345678); end
        waddr = 5'd20; din = 32'hFFFFFFFF; byte_en = 4'h0; write_en = 1'b1;
        step();
        write_en = 1'b0;
        raddr = 5'd20; read_en = 1'b1;
        step();
        read_en = 1'b0;
        checks++; if (dout2 !== 32'h12345678) begin errors++; $display("FAIL noclear_be0_noop: got %h want %h", dout2, 32'h12345678); end
        while (busy0 === 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL noclear_dut0_timeout: got %b want 0", busy0); end
    endtask

    initial begin
        reset_n  = 1'b0;
        waddr    = '0;
        din      = '0;
        write_en = 1'b0;
        byte_en  = '0;
        raddr    = '0;
        read_en  = 1'b0;
        test_reset();
        test_clear();
        test_byte_en();
        test_rdw();
        test_back_to_back();
        test_clear_preload();
        test_reset_mid_clear();
        test_no_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dual_port_ram_ext.md
Name: dual_port_ram_ext

Overview:
Parametrised simple dual-port RAM: one write port, one read port, single clock. It is the next generation of the basic M9K-style dual-port RAM used across the MCU for register files and buffers. Adds byte-enable writes, a selectable read-during-write policy, an optional output pipeline register with a read-valid strobe, and a post-reset clear sequencer that zero-fills the array.

Parameters:
ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width; must be a multiple of 8 (elaboration error otherwise)
RDW_NEW_DATA, 0, same-address read-during-write: 0 = old data, 1 = new data forwarded, byte-merged
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = ready immediately after reset

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
waddr  in  ADDR_WIDTH  write address
din  in  DATA_WIDTH  write data
write_en  in  1  write strobe
byte_en  in  DATA_WIDTH/8  per-byte write enable; bit i covers din[8i+7:8i]
raddr  in  ADDR_WIDTH  read address
read_en  in  1  read strobe
dout  out  DATA_WIDTH  read data
dout_valid  out  1  one-cycle strobe; dout holds new read data
init_busy  out  1  high while the clear sequence runs

Behaviour:
- Reset (reset_n low at a clk edge): dout=0, dout_valid=0, all pipeline valids cleared, clear counter=0. State goes to CLEAR if CLEAR_ON_RESET=1, else READY. init_busy=1 during reset and in CLEAR; in the CLEAR_ON_RESET=0 case it is 0 from the first edge with reset_n high.
- State machine: CLEAR -> READY after address 2**ADDR_WIDTH-1 is written. READY -> CLEAR only via reset.
- CLEAR: each cycle writes 0 to mem[counter], then counter+1. Takes exactly 2**ADDR_WIDTH cycles; init_busy falls on the edge that writes the last word. User write_en and read_en are ignored; dout_valid stays 0 and dout holds.
- Reset asserted mid-CLEAR: restart from address 0. Array contents are not otherwise reset.
- Write (READY): if write_en=1, mem[waddr] byte i <= din byte i for each byte_en[i]=1; other bytes unchanged. byte_en=0 with write_en=1 is a no-op.
- Read (READY): read_en=1 at edge N.
  - OUT_REG=0: dout and dout_valid=1 after edge N, visible in cycle N+1.
  - OUT_REG=1: dout and dout_valid=1 after edge N+1.
  - Back-to-back reads give one result per cycle. dout holds its last value when no read completes. dout_valid is a 1-cycle pulse per read.
- Read-during-write, raddr==waddr at the same edge:
  - RDW_NEW_DATA=0: dout returns the pre-write word.
  - RDW_NEW_DATA=1: enabled bytes come from din, other bytes from the old word.
  - Different addresses: no interaction.
- Read of an address written in the previous cycle always returns the written data.
- Reads/writes during the last CLEAR cycle are ignored; the first accepted access is in the first cycle with init_busy=0.
- Array holds no ECC. Addresses wrap naturally; every address is legal.
- Synthesis: array is inferred as block RAM. The forward path and clear mux sit outside the array.

Test Plan:
- Clear: ADDR_WIDTH=5, CLEAR_ON_RESET=1; preload mem[7]=32'hDEADBEEF, pulse reset_n low 1 cycle. Required: init_busy high exactly 32 cycles. Read addr 7 then returns 32'h0 with dout_valid one cycle after read_en.
- Byte enables: write 32'h11223344 with byte_en=4'hF to addr 3, then 32'hAABBCCDD with byte_en=4'b0101. Read addr 3 -> 32'h11BB33DD.
- Read-during-write: mem[5]=32'h0, write 32'hCAFEF00D with byte_en=4'b0011 while reading addr 5 at the same edge.
  - RDW_NEW_DATA=0 -> dout=32'h0.
  - RDW_NEW_DATA=1 -> dout=32'h0000F00D.
- Latency/streaming: OUT_REG=1; read addrs 0,1,2 on consecutive cycles after writing 10,20,30. Required: dout=10,20,30 on cycles N+2..N+4 with dout_valid high 3 cycles, then low with dout holding 30.
- Reset mid-clear: assert reset_n low at clear counter=12. Required: counter restarts at 0, init_busy high a further full 32 cycles. write_en pulses during CLEAR leave no trace (read returns 0).
- CLEAR_ON_RESET=0: after reset, init_busy=0 on the first cycle. A write then read on the next cycle returns the written value.
